// File: rtl/tick_period_meter.sv
// tick_period_meter: measures clk cycles between two rising edges of tick_in.
// Ports: clk, reset (async, active-low), start, tick_in -> ready, done_tick, ovf, q[N-1:0].
module tick_period_meter #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         tick_in,
  output logic         ready,
  output logic         done_tick,
  output logic         ovf,
  output logic [N-1:0] q
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_COUNT,
    S_DONE
  } state_t;

  localparam logic [N-1:0] CNT_ONE = N'(1);
  localparam logic [N-1:0] CNT_MAX = '1;

  state_t       r_state;
  logic         r_tick_prev;
  logic [N-1:0] r_cnt;
  logic [N-1:0] r_q;
  logic         r_ovf;
  logic         r_done;
  logic         r_ready;
  logic         w_edge;

  // tick_prev resets high so a level already high at release is no edge
  assign w_edge = tick_in & ~r_tick_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_tick_prev <= 1'b1;
      r_cnt       <= '0;
      r_q         <= '0;
      r_ovf       <= 1'b0;
      r_done      <= 1'b0;
      r_ready     <= 1'b1;
    end else begin
      r_tick_prev <= tick_in;
      r_done      <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_ARM;
            r_ready <= 1'b0;
          end
        end
        S_ARM: begin
          if (w_edge) begin
            r_state <= S_COUNT;
            r_cnt   <= CNT_ONE;
          end
        end
        S_COUNT: begin
          // an edge wins over saturation in the same cycle
          if (w_edge) begin
            r_state <= S_DONE;
            r_q     <= r_cnt;
            r_ovf   <= 1'b0;
            r_done  <= 1'b1;
          end else if (r_cnt == CNT_MAX) begin
            r_state <= S_DONE;
            r_q     <= CNT_MAX;
            r_ovf   <= 1'b1;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign ready     = r_ready;
  assign done_tick = r_done;
  assign ovf       = r_ovf;
  assign q         = r_q;

endmodule

// File: tb/tb_tick_period_meter.sv
// tb_tick_period_meter: directed bench for tick_period_meter.
// Drives an N=16 and an N=4 instance from shared stimulus.
module tb_tick_period_meter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        tick_in = 1'b1;
  logic        ready16, done16, ovf16;
  logic [15:0] q16;
  logic        ready4, done4, ovf4;
  logic [3:0]  q4;

  int n_chk = 0;
  int n_err = 0;

  tick_period_meter #(.N(16)) u16 (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .tick_in  (tick_in),
    .ready    (ready16),
    .done_tick(done16),
    .ovf      (ovf16),
    .q        (q16)
  );

  tick_period_meter #(.N(4)) u4 (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .tick_in  (tick_in),
    .ready    (ready4),
    .done_tick(done4),
    .ovf      (ovf4),
    .q        (q4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rd_q(input int sel);
    return (sel == 0) ? 32'(q16) : 32'(q4);
  endfunction

  function automatic logic rd_ovf(input int sel);
    return (sel == 0) ? ovf16 : ovf4;
  endfunction

  function automatic logic rd_done(input int sel);
    return (sel == 0) ? done16 : done4;
  endfunction

  function automatic logic rd_rdy(input int sel);
    return (sel == 0) ? ready16 : ready4;
  endfunction

  // k: cycle index, start driven in k=0 (and k=xs if xs>=0).
  // tick_in: before off it is pre_hi (forced low at off-1),
  // then high for hi cycles of every per-cycle window.
  task automatic measure(input string tag, input int sel,
                         input int off, input int per,
                         input int hi, input bit pre_hi,
                         input int xs, input int eq,
                         input int eovf, input int ek,
                         input int ncyc);
    int          ndone;
    int          dk;
    logic [31:0] dq;
    logic        dovf;
    ndone = 0;
    dk    = -1;
    dq    = 'x;
    dovf  = 1'bx;
    for (int k = 0; k < ncyc; k++) begin
      start = (k == 0) || (k == xs);
      if (k < off) tick_in = pre_hi && (k < off - 1);
      else tick_in = ((k - off) % per) < hi;
      step();
      if (k == 0) check({tag, "_rdy_fall"}, 32'(rd_rdy(sel)), 0);
      if (rd_done(sel) === 1'b1) begin
        ndone++;
        dk   = k;
        dq   = rd_q(sel);
        dovf = rd_ovf(sel);
      end
    end
    start   = 1'b0;
    tick_in = 1'b0;
    check({tag, "_ndone"}, 32'(ndone), 1);
    check({tag, "_done_cyc"}, 32'(dk), 32'(ek));
    check({tag, "_q"}, dq, 32'(eq));
    check({tag, "_ovf"}, 32'(dovf), 32'(eovf));
    check({tag, "_rdy_end"}, 32'(rd_rdy(sel)), 1);
  endtask

  initial begin
    int nd;
    // reset held with tick_in high
    reset   = 1'b0;
    tick_in = 1'b1;
    start   = 1'b0;
    step();
    step();
    check("rst_ready", 32'(ready16), 1);
    check("rst_q", 32'(q16), 0);
    check("rst_ovf", 32'(ovf16), 0);
    check("rst_done", 32'(done16), 0);
    reset = 1'b1;
    step();
    step();
    check("idle_ready", 32'(ready16), 1);
    check("idle_done", 32'(done16), 0);

    // tick_in high through start: first edge only after 0 -> 1
    measure("rst_edge", 0, 7, 3, 1, 1'b1, -1, 3, 0, 10, 14);
    measure("nom", 0, 2, 10, 1, 1'b0, -1, 10, 0, 12, 16);
    measure("tog", 0, 2, 2, 1, 1'b0, -1, 2, 0, 4, 8);
    measure("duty", 0, 2, 3, 2, 1'b0, -1, 3, 0, 5, 9);
    measure("n4_edge15", 1, 2, 15, 1, 1'b0, -1, 15, 0, 17, 21);
    measure("ign_start", 0, 2, 7, 1, 1'b0, 5, 7, 0, 9, 13);
    // single edge then silence: N=4 saturates
    measure("n4_ovf", 1, 2, 1000, 1, 1'b0, -1, 15, 1, 17, 21);

    // abort in COUNT after 5 counting cycles
    nd = 0;
    for (int k = 0; k < 8; k++) begin
      start   = (k == 0);
      tick_in = (k == 2);
      step();
      if (done4 === 1'b1) nd++;
    end
    start   = 1'b0;
    tick_in = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    check("abort_ndone", 32'(nd), 0);
    check("abort_done", 32'(done4), 0);
    check("abort_q4", 32'(q4), 0);
    check("abort_ovf4", 32'(ovf4), 0);
    check("abort_q16", 32'(q16), 0);
    check("abort_ready", 32'(ready4), 1);
    step();
    step();
    reset = 1'b1;
    measure("post_abort", 1, 2, 7, 1, 1'b0, -1, 7, 0, 9, 13);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
